alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TAG_W, 4, width of each requester's destination tag.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  bit i = requester i presents an operation.
REQ-005 req_ready  output  2  bit i = requester i's operation is accepted this cycle.
REQ-006 req_op  input  6  {op1, op0}, 3-bit ALU opcode per requester.
REQ-007 req_a  input  64  {a1, a0}, 32-bit A operand per requester.
REQ-008 req_b  input  64  {b1, b0}, 32-bit B operand per requester.
REQ-009 req_tag  input  2*TAG_W  {tag1, tag0}, opaque tag returned with the result.
REQ-010 alu_op  output  3  opcode to the shared ALU.
REQ-011 alu_a  output  32  A operand to the shared ALU.
REQ-012 alu_b  output  32  B operand to the shared ALU.
REQ-013 alu_y  input  32  combinational ALU result.
REQ-014 rsp_valid  output  1  the response register holds a result.
REQ-015 rsp_ready  input  1  the consumer takes the response this cycle.
REQ-016 rsp_id  output  1  index of the requester that owns the response.
REQ-017 rsp_tag  output  TAG_W  tag of the owning operation.
REQ-018 rsp_data  output  32  captured ALU result.

Function
REQ-019 States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); no other state bits except the round-robin pointer.
REQ-020 can_accept = EMPTY, or FULL with rsp_ready=1.
REQ-021 Grant is combinational: at most one req_ready bit is high, and only when can_accept=1 and that requester's valid bit is high.
REQ-022 Default arbitration is fixed priority: requester 0 wins when both are valid.
REQ-023 alu_op, alu_a and alu_b carry the granted requester's fields; with no grant they are all zero.
REQ-024 Handshake on requester i = req_valid[i] & req_ready[i]; at the next posedge rsp_valid=1, rsp_data=alu_y, rsp_id=i, rsp_tag=tag i (latency 1 cycle).
REQ-025 FULL with rsp_ready=1 and no handshake: go to EMPTY and clear rsp_valid at the next posedge.
REQ-026 Simultaneous drain and accept: stay FULL and load the new result with no bubble; throughput is 1 op/cycle.
REQ-027 FULL with rsp_ready=0: req_ready=00, and rsp_data/rsp_id/rsp_tag hold stable.
REQ-028 Opcodes pass through unmodified; the block does not decode them.
REQ-029 A requester that deasserts valid without a handshake loses nothing; no state changes.

Reset
REQ-030 Asserting rst asynchronously forces rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tag=0 and the round-robin pointer to 1 (requester 0 preferred first).
REQ-031 Reset mid-operation discards any pending response; no partial result appears after release.
REQ-032 During reset req_ready=00 and the ALU outputs are zero.

Configuration
REQ-033 Macro ALU_ARB_RR_EN, defined: round-robin arbitration; a 1-bit pointer names the last granted requester, and the other requester wins a tie.
REQ-034 The pointer updates only on a handshake, never on a stall.
REQ-035 Macro ALU_ARB_RR_EN, undefined: fixed priority per REQ-022; no pointer flop is synthesized.

Verification
REQ-036 Scenario: req0 valid, op=000, a=5, b=7, tag=3, rsp_ready=1 -> req_ready=01, then next cycle rsp_valid=1, rsp_data=12, rsp_id=0, rsp_tag=3.
REQ-037 Scenario: both valid for 4 cycles, rsp_ready=1 -> with RR: grants 0,1,0,1; without RR: grants 0,0,0,0.
REQ-038 Scenario: FULL with rsp_ready=0 for 3 cycles while req1 is valid -> req_ready=00, rsp fields constant; raise rsp_ready -> req1 accepted the same cycle.
REQ-039 Scenario: back-to-back op=001, a=10, b=3 then op=011, a=0, b=0 with rsp_ready=1 -> rsp_data=7 then 0xFFFFFFFF on consecutive cycles.
REQ-040 Scenario: rst asserted between a handshake and its response -> rsp_valid=0 immediately (asynchronous), no response after release, and first tie goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester, shared-ALU and response signals of
// alu_arbiter. The master side is the surrounding environment (two requesters,
// the combinational ALU and the response consumer); the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [5:0]         req_op;
  logic [63:0]        req_a;
  logic [63:0]        req_b;
  logic [2*TAG_W-1:0] req_tag;

  logic [2:0]         alu_op;
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [31:0]        alu_y;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [TAG_W-1:0]   rsp_tag;
  logic [31:0]        rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, alu_y, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_tag, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, alu_y, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_tag, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one combinational ALU. The winner's
// operands are steered to the ALU and the result is captured one cycle later in
// a single-entry response register (EMPTY/FULL), which can drain and reload in
// the same cycle for one operation per cycle.
// Configuration macro ALU_ARB_RR_EN: when defined, ties are broken round-robin
// using a 1-bit pointer to the last granted requester; when undefined, requester
// 0 always wins a tie and no pointer flop exists.
module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             can_accept;
  logic [1:0]       gnt;
  logic             handshake;
  logic             prefer1;

  logic [2:0]       op0, op1;
  logic [31:0]      a0, a1, b0, b1;
  logic [TAG_W-1:0] tag0, tag1;

  assign op0  = bus.req_op[2:0];
  assign op1  = bus.req_op[5:3];
  assign a0   = bus.req_a[31:0];
  assign a1   = bus.req_a[63:32];
  assign b0   = bus.req_b[31:0];
  assign b1   = bus.req_b[63:32];
  assign tag0 = bus.req_tag[TAG_W-1:0];
  assign tag1 = bus.req_tag[2*TAG_W-1:TAG_W];

  // A new result can be captured when the register is empty or is being drained
  // this cycle; reset blocks all grants so nothing is half-accepted.
  assign can_accept = ~rst & ((state_q == EMPTY) | bus.rsp_ready);
  assign handshake  = |gnt;

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer tracks the last granted requester and moves only when a grant is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = gnt[1];
    end
  end

  // Pointer register; resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign prefer1 = ~ptr_q;
`else
  assign prefer1 = 1'b0;
`endif

  // Combinational grant: at most one requester, only when a result can be taken.
  always_comb begin
    gnt = 2'b00;
    if (can_accept) begin
      case (bus.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prefer1 ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Steer the granted requester's fields to the ALU; idle ALU inputs sit at zero.
  always_comb begin
    bus.alu_op = 3'b000;
    bus.alu_a  = 32'd0;
    bus.alu_b  = 32'd0;
    if (gnt[0]) begin
      bus.alu_op = op0;
      bus.alu_a  = a0;
      bus.alu_b  = b0;
    end else if (gnt[1]) begin
      bus.alu_op = op1;
      bus.alu_a  = a1;
      bus.alu_b  = b1;
    end
  end

  // Response register next state: load on a handshake (even while draining),
  // otherwise empty out when the consumer takes the held result.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_tag_d  = rsp_tag_q;
    if (handshake) begin
      state_d    = FULL;
      rsp_data_d = bus.alu_y;
      rsp_id_d   = gnt[1];
      rsp_tag_d  = gnt[1] ? tag1 : tag0;
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Response register; reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rsp_data_q <= 32'd0;
      rsp_id_q   <= 1'b0;
      rsp_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_tag   = rsp_tag_q;

  // Grant sanity: one-hot, only to valid requesters, never while the register is stuck full.
  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  assert property (@(posedge clk) disable iff (rst) (gnt & ~bus.req_valid) == 2'b00);
  assert property (@(posedge clk) disable iff (rst)
                   ((state_q == FULL) && !bus.rsp_ready) |-> (gnt == 2'b00));

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks for alu_arbiter with a simple ALU model.
// Expectations follow ALU_ARB_RR_EN when the bench is built with that macro.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  alu_arbiter_if #(.TAG_W(4)) bus ();

  alu_arbiter #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared combinational ALU: 0 add, 1 sub, 2 and, 3 nor, 4 or, 5 xor, 6 shl, 7 shr.
  always_comb begin
    bus.alu_y = 32'd0;
    case (bus.alu_op)
      3'd0: bus.alu_y = bus.alu_a + bus.alu_b;
      3'd1: bus.alu_y = bus.alu_a - bus.alu_b;
      3'd2: bus.alu_y = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_y = ~(bus.alu_a | bus.alu_b);
      3'd4: bus.alu_y = bus.alu_a | bus.alu_b;
      3'd5: bus.alu_y = bus.alu_a ^ bus.alu_b;
      3'd6: bus.alu_y = bus.alu_a << bus.alu_b[4:0];
      default: bus.alu_y = bus.alu_a >> bus.alu_b[4:0];
    endcase
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    bus.req_valid = 2'b00;
    bus.req_op    = 6'd0;
    bus.req_a     = 64'd0;
    bus.req_b     = 64'd0;
    bus.req_tag   = 8'd0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_op    = {3'd1, 3'd2};
    bus.req_a     = {32'd9, 32'd8};
    bus.req_b     = {32'd7, 32'd6};
    bus.req_tag   = {4'd5, 4'd4};
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %0h expected 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_data: got %0h expected 0", bus.rsp_data); end
    n_cmp++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_id: got %0h expected 0", bus.rsp_id); end
    n_cmp++; if (bus.rsp_tag !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_tag: got %0h expected 0", bus.rsp_tag); end
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_ready: got %0h expected 0", bus.req_ready); end
    n_cmp++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 67'd0) begin n_fail++; $display("[TB] FAIL rst_alu: got op=%0h a=%0h b=%0h expected zeros", bus.alu_op, bus.alu_a, bus.alu_b); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_hold_valid: got %0h expected 0", bus.rsp_valid); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_op    = {3'd0, 3'd0};
    bus.req_a     = {32'd0, 32'd5};
    bus.req_b     = {32'd0, 32'd7};
    bus.req_tag   = {4'd0, 4'd3};
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL single_ready: got %0h expected 1", bus.req_ready); end
    n_cmp++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'd0, 32'd5, 32'd7}) begin n_fail++; $display("[TB] FAIL single_alu: got op=%0h a=%0h b=%0h expected 0/5/7", bus.alu_op, bus.alu_a, bus.alu_b); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_pre_valid: got %0h expected 0", bus.rsp_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %0h expected 1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_data !== 32'd12) begin n_fail++; $display("[TB] FAIL single_data: got %0h expected c", bus.rsp_data); end
    n_cmp++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL single_id: got %0h expected 0", bus.rsp_id); end
    n_cmp++; if (bus.rsp_tag !== 4'd3) begin n_fail++; $display("[TB] FAIL single_tag: got %0h expected 3", bus.rsp_tag); end
    bus.req_valid = 2'b00;
    #1;
    n_cmp++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 67'd0) begin n_fail++; $display("[TB] FAIL single_idle_alu: got op=%0h a=%0h b=%0h expected zeros", bus.alu_op, bus.alu_a, bus.alu_b); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_drain: got %0h expected 0", bus.rsp_valid); end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_g [4];
`ifdef ALU_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_op    = {3'd0, 3'd0};
    bus.req_a     = {32'd10, 32'd1};
    bus.req_b     = {32'd20, 32'd2};
    bus.req_tag   = {4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.req_ready !== exp_g[i]) begin n_fail++; $display("[TB] FAIL arb_grant[%0d]: got %0h expected %0h", i, bus.req_ready, exp_g[i]); end
      @(posedge clk);
      #1;
      n_cmp++; if (bus.rsp_id !== exp_g[i][1]) begin n_fail++; $display("[TB] FAIL arb_id[%0d]: got %0h expected %0h", i, bus.rsp_id, exp_g[i][1]); end
      n_cmp++; if (bus.rsp_data !== (exp_g[i][1] ? 32'd30 : 32'd3)) begin n_fail++; $display("[TB] FAIL arb_data[%0d]: got %0h expected %0h", i, bus.rsp_data, (exp_g[i][1] ? 32'd30 : 32'd3)); end
      n_cmp++; if (bus.rsp_tag !== (exp_g[i][1] ? 4'd2 : 4'd1)) begin n_fail++; $display("[TB] FAIL arb_tag[%0d]: got %0h expected %0h", i, bus.rsp_tag, (exp_g[i][1] ? 4'd2 : 4'd1)); end
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_stall();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_op    = {3'd2, 3'd0};
    bus.req_a     = {32'h0000_F0F0, 32'd100};
    bus.req_b     = {32'h0000_FF00, 32'd1};
    bus.req_tag   = {4'd9, 4'd5};
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL stall_load_ready: got %0h expected 1", bus.req_ready); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL stall_ready[%0d]: got %0h expected 0", i, bus.req_ready); end
      n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== {1'b1, 1'b0, 4'd5, 32'd101}) begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got v=%0h id=%0h tag=%0h data=%0h expected 1/0/5/65", i, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data); end
      @(posedge clk);
    end
    #1;
    bus.rsp_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL stall_release_ready: got %0h expected 2", bus.req_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data} !== {1'b1, 1'b1, 4'd9, 32'h0000_F000}) begin n_fail++; $display("[TB] FAIL stall_release_rsp: got v=%0h id=%0h tag=%0h data=%0h expected 1/1/9/f000", bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_data); end
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain: got %0h expected 0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_op    = {3'd0, 3'd1};
    bus.req_a     = {32'd0, 32'd10};
    bus.req_b     = {32'd0, 32'd3};
    bus.req_tag   = {4'd0, 4'd1};
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL b2b_ready0: got %0h expected 1", bus.req_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'd7}) begin n_fail++; $display("[TB] FAIL b2b_first: got v=%0h data=%0h expected 1/7", bus.rsp_valid, bus.rsp_data); end
    bus.req_op  = {3'd0, 3'd3};
    bus.req_a   = 64'd0;
    bus.req_b   = 64'd0;
    bus.req_tag = {4'd0, 4'd2};
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL b2b_ready1: got %0h expected 1", bus.req_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_data} !== {1'b1, 4'd2, 32'hFFFF_FFFF}) begin n_fail++; $display("[TB] FAIL b2b_second: got v=%0h tag=%0h data=%0h expected 1/2/ffffffff", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_withdraw();
    logic [1:0] exp_tie;
`ifdef ALU_ARB_RR_EN
    exp_tie = 2'b10;
`else
    exp_tie = 2'b01;
`endif
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_op    = {3'd0, 3'd0};
    bus.req_a     = {32'd1, 32'd4};
    bus.req_b     = {32'd1, 32'd4};
    bus.req_tag   = {4'd7, 4'd6};
    @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL withdraw_stall_ready: got %0h expected 0", bus.req_ready); end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_data} !== {1'b1, 4'd6, 32'd8}) begin n_fail++; $display("[TB] FAIL withdraw_hold: got v=%0h tag=%0h data=%0h expected 1/6/8", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL withdraw_drain: got %0h expected 0", bus.rsp_valid); end
    bus.req_valid = 2'b11;
    #1;
    n_cmp++; if (bus.req_ready !== exp_tie) begin n_fail++; $display("[TB] FAIL withdraw_tie: got %0h expected %0h", bus.req_ready, exp_tie); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_id !== exp_tie[1]) begin n_fail++; $display("[TB] FAIL withdraw_tie_id: got %0h expected %0h", bus.rsp_id, exp_tie[1]); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_op    = {3'd0, 3'd0};
    bus.req_a     = {32'd3, 32'd2};
    bus.req_b     = {32'd3, 32'd2};
    bus.req_tag   = {4'd8, 4'd7};
    @(posedge clk);
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'd4}) begin n_fail++; $display("[TB] FAIL midrst_loaded: got v=%0h data=%0h expected 1/4", bus.rsp_valid, bus.rsp_data); end
    rst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_data} !== {1'b0, 4'd0, 32'd0}) begin n_fail++; $display("[TB] FAIL midrst_async: got v=%0h tag=%0h data=%0h expected zeros", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    n_cmp++; if ({bus.req_ready, bus.alu_a} !== 34'd0) begin n_fail++; $display("[TB] FAIL midrst_ready: got ready=%0h alu_a=%0h expected zeros", bus.req_ready, bus.alu_a); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_rsp: got %0h expected 0", bus.rsp_valid); end
    bus.req_valid = 2'b11;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL midrst_first_tie: got %0h expected 1", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_arbitration();
    test_stall();
    test_back_to_back();
    test_withdraw();
    test_reset_mid();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
